instr_fetch: RTL and testbench

Instruction fetch stage of the single-cycle RISC-V datapath (lw/sw/beq subset). Holds the program counter, owns a small loadable instruction memory, and registers the fetched word into `INSTR`, which feeds `signextend` and the decoder. Branch redirection comes from downstream: `IMM` is the `signextend` output for the instruction currently in `INSTR`. A taken branch flushes the one wrong-path fetch.

---
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: PC, loadable read-first instruction memory, registered INSTR, one-bubble branch redirect, sticky fault halt.
// Latency 1 cycle PC->INSTR; EN=0 stalls every register, including the FSM state.
module instr_fetch #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  input  logic                     EN,
  input  logic                     BRANCH_TAKEN,
  input  logic [31:0]              IMM,
  input  logic                     LOAD_WE,
  input  logic [$clog2(DEPTH)-1:0] LOAD_ADDR,
  input  logic [31:0]              LOAD_DATA,
  output logic [31:0]              PC,
  output logic [31:0]              INSTR,
  output logic [31:0]              INSTR_PC,
  output logic                     VALID,
  output logic                     FAULT
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic [31:0] mem_q [DEPTH];

  logic [31:0] target;
  logic [31:0] fetch_word;
  logic        take_branch;
  logic        fetch_req;

  // Misaligned, or word address beyond the memory.
  function automatic logic addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0);
  endfunction

  assign target      = ipc_q + IMM;
  assign fetch_word  = mem_q[pc_q[AW+1:2]];
  assign take_branch = (state_q == RUN) && EN && BRANCH_TAKEN && valid_q;
  assign fetch_req   = EN && (((state_q == IDLE) && START) || (state_q == RUN));

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (take_branch) begin
      // Redirect replaces the wrong-path fetch with a bubble.
      pc_d    = target;
      instr_d = NOP;
      valid_d = 1'b0;
      if (addr_bad(target)) begin
        state_d = HALT;
        fault_d = 1'b1;
      end
    end else if (fetch_req) begin
      if (addr_bad(pc_q)) begin
        state_d = HALT;
        fault_d = 1'b1;
        valid_d = 1'b0;
        instr_d = NOP;
      end else begin
        state_d = RUN;
        instr_d = fetch_word;
        ipc_d   = pc_q;
        valid_d = 1'b1;
        pc_d    = pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      ipc_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end

  // Loads are independent of reset and stall; reads see the pre-write word.
  always_ff @(posedge CLK) begin
    if (LOAD_WE) mem_q[LOAD_ADDR] <= LOAD_DATA;
  end

  assign PC       = pc_q;
  assign INSTR    = instr_q;
  assign INSTR_PC = ipc_q;
  assign VALID    = valid_q;
  assign FAULT    = fault_q;
endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: observed tuple is {PC, INSTR, INSTR_PC, VALID, FAULT}.
module tb_instr_fetch;
  localparam int unsigned DEPTH = 64;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        CLK = 1'b0;
  logic        RST, START, EN, BRANCH_TAKEN, LOAD_WE;
  logic [31:0] IMM, LOAD_DATA;
  logic [5:0]  LOAD_ADDR;
  logic [31:0] PC, INSTR, INSTR_PC;
  logic        VALID, FAULT;
  logic [97:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  instr_fetch #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST), .START(START), .EN(EN), .BRANCH_TAKEN(BRANCH_TAKEN),
    .IMM(IMM), .LOAD_WE(LOAD_WE), .LOAD_ADDR(LOAD_ADDR), .LOAD_DATA(LOAD_DATA),
    .PC(PC), .INSTR(INSTR), .INSTR_PC(INSTR_PC), .VALID(VALID), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;
  assign obs = {PC, INSTR, INSTR_PC, VALID, FAULT};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [97:0] exp;
    RST = 1'b1; START = 1'b0; EN = 1'b0; BRANCH_TAKEN = 1'b0; IMM = '0;
    LOAD_WE = 1'b0; LOAD_ADDR = '0; LOAD_DATA = '0;
    step();
    RST = 1'b0;
    exp = {32'd0, NOP, 32'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL reset: got %h want %h", obs, exp); end
  endtask

  task automatic test_load();
    logic [31:0] words [5];
    logic [5:0]  addrs [5];
    logic [97:0] exp;
    words = '{32'h00001003, 32'h00001023, 32'h00001063, 32'h00000013, 32'hCAFE0013};
    addrs = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd63};
    EN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      LOAD_WE = 1'b1; LOAD_ADDR = addrs[i]; LOAD_DATA = words[i];
      step();
    end
    LOAD_WE = 1'b0;
    exp = {32'd0, NOP, 32'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL idle_hold: got %h want %h", obs, exp); end
  endtask

  task automatic test_sequential();
    logic [31:0] w [4];
    logic [97:0] exp;
    w = '{32'h00001003, 32'h00001023, 32'h00001063, 32'h00000013};
    START = 1'b1; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      START = 1'b0;
      exp = {32'(4 * (i + 1)), w[i], 32'(4 * i), 1'b1, 1'b0};
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL seq%0d: got %h want %h", i, obs, exp); end
    end
  endtask

  task automatic test_branch();
    logic [97:0] exp;
    BRANCH_TAKEN = 1'b1; IMM = 32'hFFFF_FFFC;          // 12 - 4 -> 8
    step();
    exp = {32'd8, NOP, 32'd12, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL br_redirect: got %h want %h", obs, exp); end
    IMM = 32'h0000_0002;                               // ignored: VALID is 0
    step();
    exp = {32'd12, 32'h00001063, 32'd8, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL br_ignore_bubble: got %h want %h", obs, exp); end
    IMM = 32'hFFFF_FFF8;                               // 8 - 8 -> 0
    step();
    exp = {32'd0, NOP, 32'd8, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL br_back: got %h want %h", obs, exp); end
    BRANCH_TAKEN = 1'b0;
    step();
    exp = {32'd4, 32'h00001003, 32'd0, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL br_target: got %h want %h", obs, exp); end
  endtask

  task automatic test_stall();
    logic [97:0] exp;
    EN = 1'b0; BRANCH_TAKEN = 1'b1; IMM = 32'd8; START = 1'b1;
    exp = {32'd4, 32'h00001003, 32'd0, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL stall%0d: got %h want %h", i, obs, exp); end
    end
    EN = 1'b1; BRANCH_TAKEN = 1'b0; START = 1'b0;
    step();
    exp = {32'd8, 32'h00001023, 32'd4, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL stall_resume: got %h want %h", obs, exp); end
  endtask

  task automatic test_read_first();
    logic [97:0] exp;
    LOAD_WE = 1'b1; LOAD_ADDR = 6'd2; LOAD_DATA = 32'hDEAD_0063;
    step();
    LOAD_WE = 1'b0;
    exp = {32'd12, 32'h00001063, 32'd8, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rf_old: got %h want %h", obs, exp); end
    BRANCH_TAKEN = 1'b1; IMM = 32'd0;                  // branch to self (8)
    step();
    BRANCH_TAKEN = 1'b0;
    exp = {32'd8, NOP, 32'd8, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rf_redirect: got %h want %h", obs, exp); end
    step();
    exp = {32'd12, 32'hDEAD_0063, 32'd8, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rf_new: got %h want %h", obs, exp); end
  endtask

  task automatic test_misaligned();
    logic [97:0] exp;
    BRANCH_TAKEN = 1'b1; IMM = 32'd2;                  // 8 + 2 -> 10
    step();
    exp = {32'd10, NOP, 32'd8, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL mis_fault: got %h want %h", obs, exp); end
    BRANCH_TAKEN = 1'b0; START = 1'b1; EN = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== exp) begin n_err++; $display("FAIL mis_halt%0d: got %h want %h", i, obs, exp); end
    end
    START = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [97:0] exp;
    RST = 1'b1;
    step();
    RST = 1'b0; START = 1'b1; EN = 1'b1;
    step();
    START = 1'b0;
    step();
    exp = {32'd8, 32'h00001023, 32'd4, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rst_prerun: got %h want %h", obs, exp); end
    RST = 1'b1; START = 1'b1; BRANCH_TAKEN = 1'b1; IMM = 32'hFFFF_FFFC;
    LOAD_WE = 1'b1; LOAD_ADDR = 6'd1; LOAD_DATA = 32'h1111_0023;
    step();
    RST = 1'b0; START = 1'b0; BRANCH_TAKEN = 1'b0; LOAD_WE = 1'b0;
    exp = {32'd0, NOP, 32'd0, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rst_mid: got %h want %h", obs, exp); end
    step();
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rst_idle: got %h want %h", obs, exp); end
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    exp = {32'd8, 32'h1111_0023, 32'd4, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL rst_load: got %h want %h", obs, exp); end
  endtask

  task automatic test_out_of_range();
    logic [97:0] exp;
    BRANCH_TAKEN = 1'b1; IMM = 32'd248;                // 4 + 248 -> 252, last word
    step();
    BRANCH_TAKEN = 1'b0;
    exp = {32'd252, NOP, 32'd4, 1'b0, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL oor_redirect: got %h want %h", obs, exp); end
    step();
    exp = {32'd256, 32'hCAFE_0013, 32'd252, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL oor_last: got %h want %h", obs, exp); end
    step();
    exp = {32'd256, NOP, 32'd252, 1'b0, 1'b1};
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL oor_fault: got %h want %h", obs, exp); end
    START = 1'b1;
    step();
    START = 1'b0;
    n_cmp++;
    if (obs !== exp) begin n_err++; $display("FAIL oor_halt: got %h want %h", obs, exp); end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load();
    test_sequential();
    test_branch();
    test_stall();
    test_read_first();
    test_misaligned();
    test_reset_mid();
    test_out_of_range();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
